fetch_stage: RTL and testbench

- Instruction fetch stage of the RV32I core.
- Owns the program counter and issues word fetches to instruction memory over a valid/ready request/response interface.
- Holds the fetched word in an IF/ID output register that drives the decoder and immediate generator.
- Supports decode back-pressure (stall) and EX-stage control-flow redirect with stale-response squashing. At most one request is outstanding.

---
 rtl/fetch_stage_if.sv | 35 +++
 rtl/fetch_stage.sv | 122 ++++++++++++
 tb/tb_fetch_stage.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
//------------------------------------------------------------------------------
// Module  : fetch_stage_if
// Brief   : Instruction-memory request/response channel between fetch and imem.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_stage_if;
    logic        imemReqValid;
    logic        imemReqReady;
    logic [31:0] imemReqAddr;
    logic        imemRespValid;
    logic        imemRespReady;
    logic [31:0] imemRespData;

    modport master (
        output imemReqValid,
        output imemReqAddr,
        output imemRespReady,
        input  imemReqReady,
        input  imemRespValid,
        input  imemRespData
    );

    modport slave (
        input  imemReqValid,
        input  imemReqAddr,
        input  imemRespReady,
        output imemReqReady,
        output imemRespValid,
        output imemRespData
    );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
//------------------------------------------------------------------------------
// Module  : fetch_stage
// Brief   : RV32I instruction fetch: PC, single-outstanding imem fetch, IF/ID reg.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  wire logic        clk,
    input  wire logic        reset,
    fetch_stage_if.master    imem,
    input  wire logic        redirectValid,
    input  wire logic [31:0] redirectTarget,
    input  wire logic        stall,
    output logic             instructionValid,
    output logic [31:0]      instruction,
    output logic [31:0]      instructionPc
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_instr_valid;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;

    logic        w_resp_ready;
    logic        w_req_fire;
    logic        w_resp_fire;
    logic        w_load;
    logic [31:0] w_redirect_pc;
    logic        w_unused_target_bits;

    assign w_redirect_pc        = {redirectTarget[31:2], 2'b00};
    assign w_unused_target_bits = ^redirectTarget[1:0];

    // Handshake outputs are gated by reset because the async reset only
    // settles the state register, not the combinational decode.
    assign imem.imemReqValid = (r_state == ST_REQ) && !reset;
    assign imem.imemReqAddr  = {r_pc[31:2], 2'b00};

    always_comb begin
        w_resp_ready = 1'b0;
        case (r_state)
            ST_DRAIN: w_resp_ready = 1'b1;
            ST_WAIT:  w_resp_ready = !r_instr_valid || !stall || redirectValid;
            default:  w_resp_ready = 1'b0;
        endcase
        if (reset) begin
            w_resp_ready = 1'b0;
        end
    end

    assign imem.imemRespReady = w_resp_ready;

    assign w_req_fire  = imem.imemReqValid && imem.imemReqReady;
    assign w_resp_fire = imem.imemRespValid && w_resp_ready;
    assign w_load      = (r_state == ST_WAIT) && w_resp_fire && !redirectValid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_REQ;
            r_pc          <= RESET_PC;
            r_req_pc      <= 32'h0;
            r_instr_valid <= 1'b0;
            r_instr       <= NOP_INSTR;
            r_instr_pc    <= 32'h0;
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (w_req_fire) begin
                        r_req_pc <= r_pc;
                        r_pc     <= r_pc + 32'd4;
                        r_state  <= redirectValid ? ST_DRAIN : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_resp_fire) begin
                        r_state <= ST_REQ;
                    end else if (redirectValid) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_resp_fire) begin
                        r_state <= ST_REQ;
                    end
                end
                default: r_state <= ST_REQ;
            endcase

            // Redirect overrides the sequential pc+4 written above.
            if (redirectValid) begin
                r_pc <= w_redirect_pc;
            end

            if (w_load) begin
                r_instr_valid <= 1'b1;
                r_instr       <= imem.imemRespData;
                r_instr_pc    <= r_req_pc;
            end else if (redirectValid || !stall) begin
                r_instr_valid <= 1'b0;
            end
        end
    end

    assign instructionValid = r_instr_valid;
    assign instruction      = r_instr;
    assign instructionPc    = r_instr_pc;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
//------------------------------------------------------------------------------
// Module  : tb_fetch_stage
// Brief   : Directed cycle-table bench for fetch_stage with a small imem model.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;

    localparam logic [31:0] C_NOP = 32'h0000_0013;
    localparam logic [31:0] C_I0  = 32'h0050_0093;
    localparam logic [31:0] C_I1  = 32'h00A0_0113;
    localparam logic [31:0] C_I2  = 32'h00F0_0193;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirectValid;
    logic [31:0] redirectTarget;
    logic        stall;
    logic        instructionValid;
    logic [31:0] instruction;
    logic [31:0] instructionPc;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (C_NOP)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .imem             (bus),
        .redirectValid    (redirectValid),
        .redirectTarget   (redirectTarget),
        .stall            (stall),
        .instructionValid (instructionValid),
        .instruction      (instruction),
        .instructionPc    (instructionPc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Memory model state
    logic        m_pend = 1'b0;
    int          m_cnt  = 0;
    int          cur_dly = 0;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] tgt;
        logic        rdy;
        int          dly;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_rr;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(logic st, logic rd, logic [31:0] tg, logic ry, int dl,
                                logic rv, logic [31:0] ad, logic rr, logic iv,
                                logic [31:0] ins, logic [31:0] ipc);
        vec_t v;
        v.stall = st; v.redir = rd; v.tgt = tg; v.rdy = ry; v.dly = dl;
        v.e_rv = rv; v.e_addr = ad; v.e_rr = rr; v.e_iv = iv;
        v.e_instr = ins; v.e_ipc = ipc;
        return v;
    endfunction

    function automatic logic [31:0] mem_word(logic [31:0] addr);
        case (addr)
            32'h0:   return C_I0;
            32'h4:   return C_I1;
            32'h8:   return C_I2;
            default: return addr + 32'h1300_0000;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Finishes the current cycle: sample handshakes, cross the edge, update imem.
    task automatic run_cycle();
        logic        rf;
        logic        pf;
        logic [31:0] ra;
        #1;
        rf = bus.imemReqValid && bus.imemReqReady;
        pf = bus.imemRespValid && bus.imemRespReady;
        ra = bus.imemReqAddr;
        @(posedge clk);
        #1;
        if (pf) begin
            bus.imemRespValid = 1'b0;
            m_pend = 1'b0;
        end
        if (rf) begin
            m_pend = 1'b1;
            m_cnt  = cur_dly;
            bus.imemRespData = mem_word(ra);
            if (m_cnt == 0) bus.imemRespValid = 1'b1;
        end else if (m_pend && !bus.imemRespValid) begin
            m_cnt--;
            if (m_cnt == 0) bus.imemRespValid = 1'b1;
        end
    endtask

    task automatic check_outputs(string tag, logic rv, logic [31:0] ad, logic rr,
                                 logic iv, logic [31:0] ins, logic [31:0] ipc);
        check({tag, ".reqValid"},  {31'b0, bus.imemReqValid},  {31'b0, rv});
        check({tag, ".reqAddr"},   bus.imemReqAddr,            ad);
        check({tag, ".respReady"}, {31'b0, bus.imemRespReady}, {31'b0, rr});
        check({tag, ".instrValid"}, {31'b0, instructionValid}, {31'b0, iv});
        check({tag, ".instr"},     instruction,                ins);
        check({tag, ".instrPc"},   instructionPc,              ipc);
    endtask

    initial begin
        // Reset release, back-to-back fetch of 0x0/0x4/0x8
        vecs[0]  = mk(0,0,0,1,0, 1,32'h0,  0, 0,C_NOP,32'h0);
        vecs[1]  = mk(0,0,0,1,0, 0,32'h4,  1, 0,C_NOP,32'h0);
        vecs[2]  = mk(0,0,0,1,0, 1,32'h4,  0, 1,C_I0, 32'h0);
        vecs[3]  = mk(0,0,0,1,0, 0,32'h8,  1, 0,C_I0, 32'h0);
        // Stall 5 cycles holding PC 0x4 while the 0x8 response waits
        vecs[4]  = mk(1,0,0,1,0, 1,32'h8,  0, 1,C_I1, 32'h4);
        vecs[5]  = mk(1,0,0,1,0, 0,32'hC,  0, 1,C_I1, 32'h4);
        vecs[6]  = mk(1,0,0,1,0, 0,32'hC,  0, 1,C_I1, 32'h4);
        vecs[7]  = mk(1,0,0,1,0, 0,32'hC,  0, 1,C_I1, 32'h4);
        vecs[8]  = mk(1,0,0,1,0, 0,32'hC,  0, 1,C_I1, 32'h4);
        vecs[9]  = mk(0,0,0,1,0, 0,32'hC,  1, 1,C_I1, 32'h4);
        // Fetch 0xC with 3-cycle delay, redirect to 0x100 while waiting
        vecs[10] = mk(0,0,0,1,3, 1,32'hC,  0, 1,C_I2, 32'h8);
        vecs[11] = mk(0,1,32'h100,1,0, 0,32'h10, 1, 0,C_I2, 32'h8);
        vecs[12] = mk(0,0,0,1,0, 0,32'h100,1, 0,C_I2, 32'h8);
        vecs[13] = mk(0,0,0,1,0, 0,32'h100,1, 0,C_I2, 32'h8);
        vecs[14] = mk(0,0,0,1,0, 0,32'h100,1, 0,C_I2, 32'h8);
        vecs[15] = mk(0,0,0,1,0, 1,32'h100,0, 0,C_I2, 32'h8);
        vecs[16] = mk(0,0,0,1,0, 0,32'h104,1, 0,C_I2, 32'h8);
        // Redirect to 0x203 in REQ with memory not ready
        vecs[17] = mk(0,1,32'h203,0,0, 1,32'h104,0, 1,32'h1300_0100,32'h100);
        vecs[18] = mk(0,0,0,0,0, 1,32'h200,0, 0,32'h1300_0100,32'h100);
        vecs[19] = mk(0,0,0,1,0, 1,32'h200,0, 0,32'h1300_0100,32'h100);
        vecs[20] = mk(0,0,0,1,0, 0,32'h204,1, 0,32'h1300_0100,32'h100);
        // Redirect + stall in the same cycle as a response handshake
        vecs[21] = mk(1,0,0,1,0, 1,32'h204,0, 1,32'h1300_0200,32'h200);
        vecs[22] = mk(1,1,32'h300,1,0, 0,32'h208,1, 1,32'h1300_0200,32'h200);
        vecs[23] = mk(1,0,0,1,0, 1,32'h300,0, 0,32'h1300_0200,32'h200);
        vecs[24] = mk(1,0,0,1,0, 0,32'h304,1, 0,32'h1300_0200,32'h200);
        vecs[25] = mk(0,0,0,1,0, 1,32'h304,0, 1,32'h1300_0300,32'h300);

        reset = 1'b1;
        redirectValid = 1'b0;
        redirectTarget = 32'h0;
        stall = 1'b0;
        bus.imemReqReady = 1'b0;
        bus.imemRespValid = 1'b0;
        bus.imemRespData = 32'h0;
        #1;
        check_outputs("reset", 1'b0, 32'h0, 1'b0, 1'b0, C_NOP, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 26; i++) begin
            stall            = vecs[i].stall;
            redirectValid    = vecs[i].redir;
            redirectTarget   = vecs[i].tgt;
            bus.imemReqReady = vecs[i].rdy;
            cur_dly          = vecs[i].dly;
            #2;
            check_outputs($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_addr, vecs[i].e_rr,
                          vecs[i].e_iv, vecs[i].e_instr, vecs[i].e_ipc);
            run_cycle();
        end

        // Asynchronous reset in the middle of WAIT with a response pending
        stall = 1'b0;
        redirectValid = 1'b0;
        bus.imemReqReady = 1'b0;
        cur_dly = 0;
        reset = 1'b1;
        bus.imemRespValid = 1'b0;
        m_pend = 1'b0;
        #1;
        check_outputs("midreset", 1'b0, 32'h0, 1'b0, 1'b0, C_NOP, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        check({"refetch", ".reqValid"}, {31'b0, bus.imemReqValid}, 32'h1);
        check({"refetch", ".reqAddr"},  bus.imemReqAddr, 32'h0);
        run_cycle();

        // Address wrap: fetch at 0xFFFFFFFC is followed by a fetch at 0x0
        redirectValid  = 1'b1;
        redirectTarget = 32'hFFFF_FFFC;
        #2;
        check("wrap.addrBeforeRedirect", bus.imemReqAddr, 32'h0);
        run_cycle();
        redirectValid    = 1'b0;
        bus.imemReqReady = 1'b1;
        #2;
        check_outputs("wrap0", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, C_NOP, 32'h0);
        run_cycle();
        #2;
        check_outputs("wrap1", 1'b0, 32'h0, 1'b1, 1'b0, C_NOP, 32'h0);
        run_cycle();
        #2;
        check_outputs("wrap2", 1'b1, 32'h0, 1'b0, 1'b1, 32'h12FF_FFFC, 32'hFFFF_FFFC);
        run_cycle();
        #2;
        check_outputs("wrap3", 1'b0, 32'h4, 1'b1, 1'b0, 32'h12FF_FFFC, 32'hFFFF_FFFC);
        run_cycle();
        #2;
        check_outputs("wrap4", 1'b1, 32'h4, 1'b0, 1'b1, C_I0, 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
